peak_dpu_de_buf: RTL



---
 rtl/peak_dpu_de_buf.sv | 127 ++++++++++++
 1 files changed

// File: rtl/peak_dpu_de_buf.sv
// Two-wide decoded-instruction buffer between the slot decoders and issue.
// Registered, back-pressured, in-order; serialising entries issue alone in slot 0.
module peak_dpu_de_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 64,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [1:0]    in_vld,
  input  logic [PW-1:0] in_payload0,
  input  logic [PW-1:0] in_payload1,
  input  logic [1:0]    in_serial,
  output logic          in_rdy,
  output logic [1:0]    out_vld,
  output logic [PW-1:0] out_payload0,
  output logic [PW-1:0] out_payload1,
  output logic [1:0]    out_serial,
  input  logic [1:0]    out_take,
  output logic [CW-1:0] count
);

  localparam int unsigned IW = CW - 1;

  // Entry layout: {serial, payload}
  typedef logic [PW:0] entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;

  logic [IW-1:0]   wr_idx0, wr_idx1;
  logic [IW-1:0]   rd_idx0, rd_idx1;
  entry_t          head_e, next_e;
  logic            space_ok;
  logic            push0, push1;
  logic [1:0]      take;
  logic            pop0, pop1;
  logic [CW-1:0]   n_in, n_out;

  assign count   = wr_ptr_q - rd_ptr_q;

  assign wr_idx0 = wr_ptr_q[IW-1:0];
  assign wr_idx1 = wr_idx0 + IW'(1);
  assign rd_idx0 = rd_ptr_q[IW-1:0];
  assign rd_idx1 = rd_idx0 + IW'(1);

  assign head_e  = mem_q[rd_idx0];
  assign next_e  = mem_q[rd_idx1];

  // Uses registered count only; a same-cycle pop never opens room for a push.
  assign space_ok = (count <= CW'(DEPTH - 2));
  assign in_rdy   = rst_n & ~flush & space_ok;

  always_comb begin
    out_vld      = 2'b00;
    out_payload0 = '0;
    out_payload1 = '0;
    out_serial   = 2'b00;
    out_vld[0]   = (count != '0);
    out_vld[1]   = (count >= CW'(2)) & ~head_e[PW] & ~next_e[PW];
    if (out_vld[0]) begin
      out_payload0  = head_e[PW-1:0];
      out_serial[0] = head_e[PW];
    end
    if (out_vld[1]) begin
      out_payload1  = next_e[PW-1:0];
      out_serial[1] = next_e[PW];
    end
  end

  // in_vld = 2'b10 pushes nothing; out_take = 2'b10 pops nothing.
  assign push0 = in_rdy & in_vld[0];
  assign push1 = in_rdy & (in_vld == 2'b11);
  assign take  = out_take & out_vld;
  assign pop0  = take[0];
  assign pop1  = (take == 2'b11);

  assign n_in  = CW'(push0) + CW'(push1);
  assign n_out = CW'(pop0) + CW'(pop1);

  always_comb begin
    mem_d = mem_q;
    if (push0) begin
      mem_d[wr_idx0] = {in_serial[0], in_payload0};
    end
    if (push1) begin
      mem_d[wr_idx1] = {in_serial[1], in_payload1};
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_in;
    rd_ptr_d = rd_ptr_q + n_out;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= CW'(DEPTH));
      assert (in_vld != 2'b10);
      assert (out_take != 2'b10);
      assert (!((push0 | push1) && !in_rdy));
    end
  end

endmodule
